param_regfile_top: RTL and testbench

PARAM_REGFILE_TOP -- requirements
Module: param_regfile_top

---
 rtl/regfile_pkg.sv | 29 ++
 rtl/button_oneshot.sv | 32 +++
 rtl/param_regfile_top.sv | 126 ++++++++++++
 tb/tb_param_regfile_top.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_pkg: ALU opcodes and display-slice helpers for param_regfile_top |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package regfile_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0110,
    OP_SLT = 4'b0111,
    OP_XOR = 4'b1101
  } alu_op_t;

  localparam int c_LED_W = 16;

  function automatic int slice_count(input int data_width);
    return data_width / c_LED_W;
  endfunction

  // A single-slice design still needs a 1-bit counter to keep the port legal.
  function automatic int slice_width(input int data_width);
    return (slice_count(data_width) > 1) ? $clog2(slice_count(data_width)) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/button_oneshot.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | button_oneshot: 2-flop synchroniser plus rising-edge detector        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module button_oneshot (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_pulse
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_btn;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_pulse = r_sync & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/param_regfile_top.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | param_regfile_top: button-driven register file with ALU and LED view |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module param_regfile_top
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32
) (
  input  logic        clk,
  input  logic        btnu,
  input  logic        btnl,
  input  logic        btnc,
  input  logic        btnd,
  input  logic [15:0] sw,
  output logic [15:0] led
);

  localparam int c_ADDR_W  = $clog2(NUM_REGS);
  localparam int c_SLICES  = slice_count(DATA_WIDTH);
  localparam int c_SLICE_W = slice_width(DATA_WIDTH);
  localparam logic [c_SLICE_W-1:0] c_LAST_SLICE = c_SLICE_W'(c_SLICES - 1);

  logic rst;
  assign rst = btnu;

  logic w_load;
  logic w_exec;
  logic w_next;

  button_oneshot u_load (.clk(clk), .rst(rst), .i_btn(btnl), .o_pulse(w_load));
  button_oneshot u_exec (.clk(clk), .rst(rst), .i_btn(btnc), .o_pulse(w_exec));
  button_oneshot u_next (.clk(clk), .rst(rst), .i_btn(btnd), .o_pulse(w_next));

  logic [c_ADDR_W-1:0]   r_rs1;
  logic [c_ADDR_W-1:0]   r_rs2;
  logic [c_ADDR_W-1:0]   r_rd;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] r_read_a;
  logic [DATA_WIDTH-1:0] r_read_b;
  logic [c_SLICE_W-1:0]  r_slice;

  alu_op_t               w_op;
  logic                  w_slt;
  logic [DATA_WIDTH-1:0] w_alu;
  logic [DATA_WIDTH-1:0] w_imm;
  logic [DATA_WIDTH-1:0] w_wr_data;
  logic                  w_we;

  assign w_op  = alu_op_t'(sw[3:0]);
  assign w_slt = $signed(r_read_a) < $signed(r_read_b);
  assign w_imm = {{(DATA_WIDTH-15){sw[14]}}, sw[14:0]};

  always_comb begin
    w_alu = r_read_a + r_read_b;
    case (w_op)
      OP_AND:  w_alu = r_read_a & r_read_b;
      OP_OR:   w_alu = r_read_a | r_read_b;
      OP_ADD:  w_alu = r_read_a + r_read_b;
      OP_SUB:  w_alu = r_read_a - r_read_b;
      OP_SLT:  w_alu = {{(DATA_WIDTH-1){1'b0}}, w_slt};
      OP_XOR:  w_alu = r_read_a ^ r_read_b;
      default: w_alu = r_read_a + r_read_b;
    endcase
  end

  // The write uses the address registers as they stand before this edge,
  // so a simultaneous load cannot redirect it.
  assign w_wr_data = sw[15] ? w_imm : w_alu;
  assign w_we      = w_exec && (r_rd != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rs1 <= '0;
      r_rs2 <= '0;
      r_rd  <= '0;
    end else if (w_load) begin
      r_rs1 <= sw[c_ADDR_W-1:0];
      r_rs2 <= sw[5 +: c_ADDR_W];
      r_rd  <= sw[10 +: c_ADDR_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_we) begin
      r_regs[r_rd] <= w_wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_read_a <= '0;
      r_read_b <= '0;
    end else begin
      r_read_a <= (w_we && (r_rd == r_rs1)) ? w_wr_data : r_regs[r_rs1];
      r_read_b <= (w_we && (r_rd == r_rs2)) ? w_wr_data : r_regs[r_rs2];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slice <= '0;
    end else if (w_load) begin
      r_slice <= '0;
    end else if (w_next) begin
      r_slice <= (r_slice == c_LAST_SLICE) ? '0 : r_slice + 1'b1;
    end
  end

  always_comb begin
    led = '0;
    for (int i = 0; i < c_SLICES; i++) begin
      if (r_slice == c_SLICE_W'(i)) begin
        led = r_read_a[c_LED_W*i +: c_LED_W];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_param_regfile_top.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_param_regfile_top: directed vectors for 32x32 and 64x8 instances  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_param_regfile_top;

  localparam int K_L = 1;
  localparam int K_C = 2;
  localparam int K_D = 4;

  typedef struct {
    int          kind;
    logic [15:0] swv;
    int          reps;
    logic [15:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        btnu, btnl, btnc, btnd;
  logic [15:0] sw;
  logic [15:0] led;
  logic        btnu64, btnl64, btnc64, btnd64;
  logic [15:0] sw64;
  logic [15:0] led64;

  int checks   = 0;
  int failures = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  param_regfile_top dut (
    .clk(clk), .btnu(btnu), .btnl(btnl), .btnc(btnc), .btnd(btnd), .sw(sw), .led(led)
  );

  param_regfile_top #(.DATA_WIDTH(64), .NUM_REGS(8)) dut64 (
    .clk(clk), .btnu(btnu64), .btnl(btnl64), .btnc(btnc64), .btnd(btnd64), .sw(sw64), .led(led64)
  );

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: led=0x%04h expected 0x%04h", name, got, exp);
    end
  endtask

  task automatic press(input int kind, input logic [15:0] s);
    @(negedge clk);
    sw   = s;
    btnl = (kind & K_L) != 0;
    btnc = (kind & K_C) != 0;
    btnd = (kind & K_D) != 0;
    repeat (3) @(negedge clk);
    btnl = 1'b0; btnc = 1'b0; btnd = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic press64(input int kind, input logic [15:0] s);
    @(negedge clk);
    sw64   = s;
    btnl64 = (kind & K_L) != 0;
    btnc64 = (kind & K_C) != 0;
    btnd64 = (kind & K_D) != 0;
    repeat (3) @(negedge clk);
    btnl64 = 1'b0; btnc64 = 1'b0; btnd64 = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  function automatic vec_t mk(input int k, input logic [15:0] s, input int r, input logic [15:0] e);
    vec_t v;
    v.kind = k; v.swv = s; v.reps = r; v.exp = e;
    return v;
  endfunction

  initial begin
    // Runs after the fixed 0x1405/0x8505 preamble: rs1=rd=5, R5=0x505.
    vecs.push_back(mk(K_L, 16'h0401, 1, 16'h0000));
    vecs.push_back(mk(K_C, 16'hFFFF, 1, 16'hFFFF));
    vecs.push_back(mk(K_D, 16'h0000, 1, 16'hFFFF));
    vecs.push_back(mk(K_D, 16'h0000, 1, 16'hFFFF));
    vecs.push_back(mk(K_L, 16'h0802, 1, 16'h0000));
    vecs.push_back(mk(K_C, 16'h8202, 1, 16'h0202));
    vecs.push_back(mk(K_L, 16'h0841, 1, 16'hFFFF));
    vecs.push_back(mk(K_C, 16'h000D, 1, 16'hFFFF));
    vecs.push_back(mk(K_L, 16'h0002, 1, 16'hFDFD));
    vecs.push_back(mk(K_D, 16'h0002, 1, 16'hFFFF));
    vecs.push_back(mk(K_D, 16'h0002, 1, 16'hFDFD));
    vecs.push_back(mk(K_D, 16'h0002, 1, 16'hFFFF));
    vecs.push_back(mk(K_L, 16'h0002, 1, 16'hFDFD));
    vecs.push_back(mk(K_L, 16'h0802, 1, 16'hFDFD));
    vecs.push_back(mk(K_C, 16'h8202, 1, 16'h0202));
    vecs.push_back(mk(K_L, 16'h7C41, 1, 16'hFFFF));
    vecs.push_back(mk(K_C, 16'h0007, 1, 16'hFFFF));
    vecs.push_back(mk(K_L, 16'h7C1F, 1, 16'h0001));
    vecs.push_back(mk(K_L, 16'h7C22, 1, 16'h0202));
    vecs.push_back(mk(K_C, 16'h0007, 1, 16'h0202));
    vecs.push_back(mk(K_L, 16'h7C1F, 1, 16'h0000));
    vecs.push_back(mk(K_L, 16'h0000, 1, 16'h0000));
    vecs.push_back(mk(K_C, 16'h8123, 1, 16'h0000));
    vecs.push_back(mk(K_L, 16'h0C63, 1, 16'h0000));
    vecs.push_back(mk(K_C, 16'hA000, 1, 16'h2000));
    vecs.push_back(mk(K_C, 16'h0002, 18, 16'h0000));
    vecs.push_back(mk(K_D, 16'h0002, 1, 16'h8000));
    vecs.push_back(mk(K_L, 16'h1004, 1, 16'h0000));
    vecs.push_back(mk(K_C, 16'h8001, 1, 16'h0001));
    vecs.push_back(mk(K_L, 16'h0C83, 1, 16'h0000));
    vecs.push_back(mk(K_C, 16'h0006, 1, 16'hFFFF));
    vecs.push_back(mk(K_D, 16'h0006, 1, 16'h7FFF));
    vecs.push_back(mk(K_C, 16'h0002, 1, 16'h8000));
    vecs.push_back(mk(K_C, 16'h0003, 1, 16'h8000));
    vecs.push_back(mk(K_C, 16'h0001, 1, 16'h8000));
    vecs.push_back(mk(K_C, 16'h0000, 1, 16'h0000));
    vecs.push_back(mk(K_D, 16'h0000, 1, 16'h0001));
    vecs.push_back(mk(K_C, 16'h000D, 1, 16'h0000));
    vecs.push_back(mk(K_C, 16'h0006, 1, 16'hFFFF));
    vecs.push_back(mk(K_D, 16'h0006, 1, 16'hFFFF));

    btnu = 1'b1; btnl = 1'b0; btnc = 1'b0; btnd = 1'b0; sw = '0;
    btnu64 = 1'b1; btnl64 = 1'b0; btnc64 = 1'b0; btnd64 = 1'b0; sw64 = '0;
    repeat (3) @(negedge clk);
    check("reset_led", led, 16'h0000);
    check("reset_led64", led64, 16'h0000);
    btnu = 1'b0; btnu64 = 1'b0;
    repeat (2) @(negedge clk);

    // Exact latency of an immediate write, then hold the button.
    press(K_L, 16'h1405);
    check("load_r5", led, 16'h0000);
    @(negedge clk);
    sw = 16'h8505; btnc = 1'b1;
    @(negedge clk);
    check("imm_edge_k", led, 16'h0000);
    @(negedge clk);
    check("imm_edge_k1", led, 16'h0000);
    @(negedge clk);
    check("imm_edge_k2", led, 16'h0505);
    sw = 16'h8123;
    repeat (6) @(negedge clk);
    check("held_one_write", led, 16'h0505);
    btnc = 1'b0;
    repeat (3) @(negedge clk);

    foreach (vecs[i]) begin
      repeat (vecs[i].reps) press(vecs[i].kind, vecs[i].swv);
      check($sformatf("vec%0d", i), led, vecs[i].exp);
    end

    // Load and execute together: R3 <= R3 - R4 with old addresses, view moves to R6.
    press(K_L | K_C, 16'h1806);
    check("ld_ex_new_view", led, 16'h0000);
    press(K_L, 16'h0C03);
    check("ld_ex_old_rd", led, 16'hFFFE);
    press(K_L | K_D, 16'h0C03);
    check("ld_beats_next", led, 16'hFFFE);

    // 64-bit instance: four slices and wrap.
    press64(K_L, 16'h0401);
    check("w64_load", led64, 16'h0000);
    press64(K_C, 16'hFFFF);
    check("w64_slice0", led64, 16'hFFFF);
    for (int s = 1; s <= 4; s++) begin
      press64(K_D, 16'h0000);
      check($sformatf("w64_ones_step%0d", s), led64, 16'hFFFF);
    end
    press64(K_L, 16'h0802);
    press64(K_C, 16'h8123);
    check("w64_r2_s0", led64, 16'h0123);
    for (int s = 1; s <= 3; s++) begin
      press64(K_D, 16'h0000);
      check($sformatf("w64_r2_s%0d", s), led64, 16'h0000);
    end
    press64(K_D, 16'h0000);
    check("w64_r2_wrap", led64, 16'h0123);

    // Async reset with a write pulse in flight.
    press64(K_L, 16'h0401);
    press64(K_D, 16'h0000);
    check("w64_pre_rst", led64, 16'hFFFF);
    @(negedge clk);
    sw64 = 16'h8042; btnc64 = 1'b1;
    @(posedge clk);
    #3 btnu64 = 1'b1;
    #1 check("w64_async_rst", led64, 16'h0000);
    @(negedge clk);
    btnc64 = 1'b0;
    repeat (2) @(negedge clk);
    btnu64 = 1'b0;
    repeat (4) @(negedge clk);
    check("w64_post_rst", led64, 16'h0000);
    press64(K_L, 16'h0401);
    check("w64_no_partial", led64, 16'h0000);
    press64(K_C, 16'h8042);
    check("w64_after_rst_wr", led64, 16'h0042);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
